// File: rtl/outport_rr_arbiter.sv
// Output-port arbiter for one NoC router outport: round-robin head-flit arbitration,
// head-to-tail wormhole lock and per-VC downstream credit tracking.
module outport_rr_arbiter #(
    parameter int unsigned PORTS_CNT     = 7,
    parameter int unsigned LOG_PORTS_CNT = 3,
    parameter int unsigned VC_CNT        = 2,
    parameter int unsigned LOG_VC        = 1,
    parameter int unsigned CREDIT_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS_CNT-1:0]        req,
    input  logic [PORTS_CNT-1:0]        req_head,
    input  logic [PORTS_CNT-1:0]        req_tail,
    input  logic [PORTS_CNT*LOG_VC-1:0] req_vc,
    input  logic                        credit_in,
    input  logic [LOG_VC-1:0]           credit_vc,
    output logic [PORTS_CNT-1:0]        gnt,
    output logic [LOG_PORTS_CNT-1:0]    gnt_id,
    output logic                        gnt_valid,
    output logic                        fire,
    output logic                        credit_err
);

    localparam int unsigned CreditW = $clog2(CREDIT_DEPTH + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                           state_q, state_d;
    logic [LOG_PORTS_CNT-1:0]         rr_ptr_q, rr_ptr_d;
    logic [LOG_PORTS_CNT-1:0]         owner_q, owner_d;
    logic [LOG_VC-1:0]                owner_vc_q, owner_vc_d;
    logic                             credit_err_q, credit_err_d;
    logic [VC_CNT-1:0][CreditW-1:0]   credit_q;
    logic [VC_CNT-1:0]                credit_ovf;
    logic [PORTS_CNT-1:0][LOG_VC-1:0] req_vc_arr;
    logic [PORTS_CNT-1:0]             eligible;
    logic                             pick_valid;
    logic [LOG_PORTS_CNT-1:0]         pick_id;

    assign req_vc_arr = req_vc;

    // A port may win only with a head flit whose requested VC has downstream space.
    for (genvar g = 0; g < PORTS_CNT; g++) begin : g_elig
        assign eligible[g] = req[g] & req_head[g] & (credit_q[req_vc_arr[g]] != '0);
    end

    // Round-robin search starting just after the last packet's owner.
    always_comb begin : p_pick
        int unsigned idx;
        logic [LOG_PORTS_CNT-1:0] cand;
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = 0;
        cand       = '0;
        for (int unsigned k = 1; k <= PORTS_CNT; k++) begin
            idx  = (32'(rr_ptr_q) + k) % PORTS_CNT;
            cand = LOG_PORTS_CNT'(idx);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Outputs come straight from the lock state; fire also needs the owner's flit and a credit.
    always_comb begin
        gnt_valid = (state_q == StBusy);
        gnt       = '0;
        gnt_id    = '0;
        if (gnt_valid) begin
            gnt[owner_q] = 1'b1;
            gnt_id       = owner_q;
        end
        fire       = gnt_valid & req[owner_q] & (credit_q[owner_vc_q] != '0);
        credit_err = credit_err_q;
    end

    // Lock FSM: arbitrate only in idle, release the lock when the tail flit transfers.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        owner_vc_d = owner_vc_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d    = pick_id;
                    owner_vc_d = req_vc_arr[pick_id];
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (fire && req_tail[owner_q]) begin
                    rr_ptr_d = owner_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Lock state and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= LOG_PORTS_CNT'(PORTS_CNT - 1);
            owner_q    <= '0;
            owner_vc_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            owner_vc_q <= owner_vc_d;
        end
    end

    // One credit counter per downstream VC; a return and a consume on the same VC cancel out.
    for (genvar g = 0; g < VC_CNT; g++) begin : g_credit
        logic               inc, dec;
        logic [CreditW-1:0] cnt_q, cnt_d;

        assign inc           = credit_in & (credit_vc == LOG_VC'(g));
        assign dec           = fire & (owner_vc_q == LOG_VC'(g));
        assign credit_ovf[g] = inc & ~dec & (cnt_q == CreditW'(CREDIT_DEPTH));
        assign credit_q[g]   = cnt_q;

        // Saturate on overflow so a spurious return cannot inflate the count.
        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec && !credit_ovf[g]) begin
                cnt_d = cnt_q + CreditW'(1);
            end else if (dec && !inc) begin
                cnt_d = cnt_q - CreditW'(1);
            end
        end

        // Credit counter register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= CreditW'(CREDIT_DEPTH);
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Overflow flag is sticky until reset.
    assign credit_err_d = credit_err_q | (|credit_ovf);

    // Sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_err_q <= 1'b0;
        end else begin
            credit_err_q <= credit_err_d;
        end
    end

endmodule

// File: tb/tb_outport_rr_arbiter.sv
// Directed, table-driven bench for outport_rr_arbiter (7 ports, 2 VCs, 4 credits per VC).
module tb_outport_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] req, req_head, req_tail, req_vc;
    logic       credit_in;
    logic [0:0] credit_vc;
    logic [6:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid, fire, credit_err;

    int checks = 0;
    int errors = 0;
    int row    = 0;

    typedef struct {
        logic       rst;
        logic [6:0] req, head, tail, vc;
        logic       cin;
        logic       cvc;
        logic       e_valid;
        logic [2:0] e_id;
        logic       e_fire;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    outport_rr_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_head   (req_head),
        .req_tail   (req_tail),
        .req_vc     (req_vc),
        .credit_in  (credit_in),
        .credit_vc  (credit_vc),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .gnt_valid  (gnt_valid),
        .fire       (fire),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] p(input int i);
        logic [6:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic add(input logic rst, input logic [6:0] rq, input logic [6:0] hd,
                       input logic [6:0] tl, input logic [6:0] vc, input logic cin,
                       input logic cvc, input logic ev, input logic [2:0] eid,
                       input logic ef, input logic ee);
        vec_t v;
        v.rst = rst; v.req = rq; v.head = hd; v.tail = tl; v.vc = vc;
        v.cin = cin; v.cvc = cvc; v.e_valid = ev; v.e_id = eid; v.e_fire = ef; v.e_err = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, check mid-cycle, then clock.
    task automatic run_row(input vec_t v);
        logic [6:0] e_gnt;
        rst_n     = ~v.rst;
        req       = v.req;
        req_head  = v.head;
        req_tail  = v.tail;
        req_vc    = v.vc;
        credit_in = v.cin;
        credit_vc = v.cvc;
        #3;
        e_gnt = v.e_valid ? p(int'(v.e_id)) : 7'd0;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("gnt_id", 32'(gnt_id), v.e_valid ? 32'(v.e_id) : 32'd0);
        chk("gnt_valid", 32'(gnt_valid), 32'(v.e_valid));
        chk("fire", 32'(fire), 32'(v.e_fire));
        chk("credit_err", 32'(credit_err), 32'(v.e_err));
        row++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] all;
        vec_t       h;
        all = 7'h7f;

        // Reset state.
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Ports 2 and 5 contend; port 2 sends head/body/tail, credits returned as consumed.
        add(0, p(2)|p(5), p(2)|p(5), 0,    0, 0, 0, 0, 0, 0, 0);
        add(0, p(2)|p(5), p(2)|p(5), 0,    0, 1, 0, 1, 2, 1, 0);
        add(0, p(2)|p(5), p(5),      0,    0, 1, 0, 1, 2, 1, 0);
        add(0, p(2)|p(5), p(5),      p(2), 0, 1, 0, 1, 2, 1, 0);
        add(0, p(5),      p(5),      p(5), 0, 0, 0, 0, 0, 0, 0);
        add(0, p(2)|p(5), p(2)|p(5), p(2)|p(5), 0, 1, 0, 1, 5, 1, 0);
        add(0, p(2)|p(5), p(2)|p(5), p(2)|p(5), 0, 0, 0, 0, 0, 0, 0);
        add(0, p(2)|p(5), p(2)|p(5), p(2)|p(5), 0, 1, 0, 1, 2, 1, 0);
        add(0, p(2)|p(5), p(2)|p(5), p(2)|p(5), 0, 0, 0, 0, 0, 0, 0);
        add(0, p(2)|p(5), p(2)|p(5), p(2)|p(5), 0, 1, 0, 1, 5, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // All ports stream single-flit packets: 0..6 then wrap to 0, two cycles each.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            add(0, all, all, all, 0, 0, 0, 0, 0, 0, 0);
            add(0, all, all, all, 0, 1, 0, 1, 3'(k % 7), 1, 0);
        end

        // Credit exhaustion on vc0, stall, late credit, then overflow on vc1.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, p(0), p(0), 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, p(0), p(0), 0, 0, 0, 0, 1, 0, 1, 0);
        add(0, p(0), 0,    0, 0, 0, 0, 1, 0, 1, 0);
        add(0, p(0), 0,    0, 0, 0, 0, 1, 0, 1, 0);
        add(0, p(0), 0,    0, 0, 0, 0, 1, 0, 1, 0);
        // Owner switches its vc (ignored) and port 3 has a vc1 head: lock held, no fire.
        add(0, p(0)|p(3), p(3), 0,    p(0)|p(3), 0, 0, 1, 0, 0, 0);
        add(0, p(0)|p(3), p(3), 0,    p(0)|p(3), 1, 0, 1, 0, 0, 0);
        add(0, p(0)|p(3), p(3), p(0), p(0)|p(3), 0, 0, 1, 0, 1, 0);
        add(0, p(3), p(3), p(3), p(3), 0, 0, 0, 0, 0, 0);
        add(0, p(3), p(3), p(3), p(3), 1, 1, 1, 3, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        // vc0 is empty, so port 0's head waits until a credit comes back.
        add(0, p(0), p(0), p(0), 0, 0, 0, 0, 0, 0, 1);
        add(0, p(0), p(0), p(0), 0, 1, 0, 0, 0, 0, 1);
        add(0, p(0), p(0), p(0), 0, 0, 0, 0, 0, 0, 1);
        add(0, p(0), p(0), p(0), 0, 0, 0, 1, 0, 1, 1);
        // Body flits alone never win.
        add(0, p(1), 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, p(1), 0, 0, 0, 0, 0, 0, 0, 0, 1);

        rst_n = 1'b0;
        req = '0; req_head = '0; req_tail = '0; req_vc = '0;
        credit_in = 1'b0; credit_vc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_row(vecs[i]);

        // Reset mid-packet: port 4 drains two vc1 credits, then reset aborts the lock.
        h.cin = 0; h.cvc = 0; h.tail = 0; h.e_err = 0;
        h.rst = 1; h.req = 0; h.head = 0; h.vc = 0;
        h.e_valid = 0; h.e_id = 0; h.e_fire = 0;
        run_row(h);
        h.rst = 0; h.req = p(4); h.head = p(4); h.vc = p(4);
        run_row(h);
        h.e_valid = 1; h.e_id = 4; h.e_fire = 1;
        run_row(h);
        h.head = 0;
        run_row(h);
        // Asynchronous reset: outputs must drop before any clock edge.
        h.rst = 1; h.e_valid = 0; h.e_id = 0; h.e_fire = 0;
        run_row(h);
        // After release port 0 wins again and vc1 has a full four credits.
        h.rst = 0; h.req = p(0)|p(4); h.head = p(0)|p(4); h.vc = p(0)|p(4);
        run_row(h);
        h.e_valid = 1; h.e_id = 0; h.e_fire = 1;
        run_row(h);
        h.head = p(4);
        run_row(h);
        run_row(h);
        run_row(h);
        h.e_fire = 0;
        run_row(h);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
